// File: rtl/mem_arbiter.sv
// Arbitrates one single-port BSRAM between instruction fetch and load/store.
// Data accesses win by default; a starvation counter forces a fetch win.
module mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       fetch_win;

  // Grants are masked while reset is held so the macro sees no access.
  always_comb begin
    fetch_win = if_req && (!d_req || (starve_q == STARVE_LIM));
    if_gnt    = !reset && fetch_win;
    d_gnt     = !reset && d_req && !fetch_win;
    mem_ce    = if_gnt | d_gnt;
    mem_wre   = d_gnt & d_we;
    mem_ad    = if_gnt ? if_addr : d_addr;
    mem_din   = d_wdata;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_FETCH);
  assign d_rvalid  = (owner_q == OWN_DATA);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a behavioural BSRAM attached.
module tb_mem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_ce, mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) mem[mem_ad] <= mem_din;
      else         mem_dout <= mem[mem_ad];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              e_if_gnt;
    logic              e_d_gnt;
    logic              e_wre;
    logic              e_if_rv;
    logic              e_d_rv;
    logic [DATA_W-1:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_f, prev_d, exp_f;
    logic [ADDR_W-1:0] exp_ad;

    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[0] = 32'h0050_0113;
    mem[1] = 32'h00C0_0193;
    mem[2] = 32'hFF71_8393;

    //          ifr ifa   dr dwe da    wdata  ifg dg wre ifrv drv rdata
    vecs[0] = '{1, 11'd0, 0, 0, 11'd0, 32'h0, 1, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 11'd1, 0, 0, 11'd0, 32'h0, 1, 0, 0, 1, 0, 32'h0050_0113};
    vecs[2] = '{1, 11'd2, 0, 0, 11'd0, 32'h0, 1, 0, 0, 1, 0, 32'h00C0_0193};
    vecs[3] = '{0, 11'd0, 0, 0, 11'd0, 32'h0, 0, 0, 0, 1, 0, 32'hFF71_8393};
    vecs[4] = '{0, 11'd0, 1, 1, 11'd5, 32'h19, 0, 1, 1, 0, 0, 32'h0};
    vecs[5] = '{0, 11'd0, 1, 0, 11'd5, 32'h0, 0, 1, 0, 0, 0, 32'h0};
    vecs[6] = '{1, 11'd1, 0, 0, 11'd0, 32'h0, 1, 0, 0, 0, 1, 32'h19};
    vecs[7] = '{0, 11'd0, 1, 0, 11'd5, 32'h0, 0, 1, 0, 1, 0, 32'h00C0_0193};
    vecs[8] = '{0, 11'd0, 0, 0, 11'd0, 32'h0, 0, 0, 0, 0, 1, 32'h19};
    vecs[9] = '{0, 11'd0, 0, 0, 11'd0, 32'h0, 0, 0, 0, 0, 0, 32'h0};

    // Requests asserted during reset must not be granted.
    if_req = 1'b1; d_req = 1'b1;
    #2;
    chk("rst_if_gnt", {31'b0, if_gnt}, 0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("rst_mem_ce", {31'b0, mem_ce}, 0);
    chk("rst_mem_wre", {31'b0, mem_wre}, 0);
    chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      #1;
      chk($sformatf("v%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, vecs[i].e_d_gnt});
      chk($sformatf("v%0d_mem_ce", i), {31'b0, mem_ce},
          {31'b0, vecs[i].e_if_gnt | vecs[i].e_d_gnt});
      chk($sformatf("v%0d_mem_wre", i), {31'b0, mem_wre}, {31'b0, vecs[i].e_wre});
      chk($sformatf("v%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].e_if_rv});
      chk($sformatf("v%0d_d_rvalid", i), {31'b0, d_rvalid}, {31'b0, vecs[i].e_d_rv});
      if (vecs[i].e_if_gnt | vecs[i].e_d_gnt) begin
        exp_ad = vecs[i].e_if_gnt ? vecs[i].if_addr : vecs[i].d_addr;
        chk($sformatf("v%0d_mem_ad", i), {21'b0, mem_ad}, {21'b0, exp_ad});
      end
      if (vecs[i].e_wre) chk($sformatf("v%0d_mem_din", i), mem_din, vecs[i].d_wdata);
      if (vecs[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_rv) chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_rdata);
    end

    // Continuous contention: DDDDF repeating, read data follows its owner.
    prev_f = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 11'd0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 11'd5;
      #1;
      exp_f = (c % 5 == 4);
      chk($sformatf("cont%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, exp_f});
      chk($sformatf("cont%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, !exp_f});
      chk($sformatf("cont%0d_both", c), {31'b0, if_gnt & d_gnt}, 0);
      chk($sformatf("cont%0d_if_rv", c), {31'b0, if_rvalid}, {31'b0, prev_f});
      chk($sformatf("cont%0d_d_rv", c), {31'b0, d_rvalid}, {31'b0, prev_d});
      if (prev_f) chk($sformatf("cont%0d_if_rdata", c), if_rdata, 32'h0050_0113);
      if (prev_d) chk($sformatf("cont%0d_d_rdata", c), d_rdata, 32'h19);
      prev_f = exp_f; prev_d = !exp_f;
    end

    // Three denials, one dropped fetch cycle, then four more denials before fetch wins.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if_req = (c != 3); d_req = 1'b1;
      #1;
      exp_f = (c == 8);
      chk($sformatf("drop%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, exp_f});
      chk($sformatf("drop%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, !exp_f});
    end

    // Async reset one cycle after a data-read grant.
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 11'd1;
    #1;
    chk("rr_d_gnt", {31'b0, d_gnt}, 1);
    @(negedge clk);
    #1;
    chk("rr_d_rvalid_pre", {31'b0, d_rvalid}, 1);
    chk("rr_d_rdata_pre", d_rdata, 32'h00C0_0193);
    #1;
    reset = 1'b1;
    #1;
    chk("rr_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("rr_if_rvalid", {31'b0, if_rvalid}, 0);
    chk("rr_gnts", {30'b0, if_gnt, d_gnt}, 0);
    chk("rr_mem", {30'b0, mem_ce, mem_wre}, 0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post%0d_rvalid", c), {30'b0, if_rvalid, d_rvalid}, 0);
    end

    // Counter must start from zero after reset: DDDDF again.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      exp_f = (c == 4);
      chk($sformatf("prst%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, exp_f});
      chk($sformatf("prst%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, !exp_f});
    end

    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
